dmux_stream: RTL and testbench

Parametrised, registered N-way demultiplexer for the HACK datapath: routes a WIDTH-bit word from one valid/ready input stream to one of CHANNELS output streams selected by `in_sel`, or to all of them in broadcast mode. Each output channel has a one-entry holding register, so a stalled consumer blocks only its own channel. Sits between the CPU/memory write path and banked peripherals (RAM banks, screen and keyboard blocks) in place of the combinational 1-bit demux trees.

---
 rtl/dmux_stream.sv | 71 +++++++
 tb/tb_dmux_stream.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_stream.sv
// dmux_stream: registered N-way valid/ready demultiplexer with broadcast.
// Each output channel owns a one-entry holding register.
module dmux_stream #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [$clog2(CHANNELS)-1:0] in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W:0] CH_L = CHANNELS[SEL_W:0];

  logic [CHANNELS-1:0] open_ch;
  logic [CHANNELS-1:0] load;
  logic                in_range;
  logic                xfer;

  assign open_ch  = ~out_valid | out_ready;
  assign in_range = {1'b0, in_sel} < CH_L;

  // Out-of-range requests are always taken so a bad address cannot wedge the producer.
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast) begin
      in_ready = &open_ch;
    end else if (in_range) begin
      in_ready = open_ch[in_sel];
    end
  end

  assign xfer = in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      load[k] = xfer &
        (in_bcast | (in_range & (in_sel == SEL_W'(k))));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= '0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (load[k]) begin
          out_valid[k]               <= 1'b1;
          out_data[k*WIDTH +: WIDTH] <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
      if (xfer & ~in_bcast & ~in_range) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmux_stream.sv
// tb_dmux_stream: directed and random checks of dmux_stream
// against a channel-occupancy reference model.
module tb_dmux_stream;

  localparam int W  = 16;
  localparam int CH = 8;
  localparam int CB = 6;

  logic          clk = 0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic [2:0]    in_sel;
  logic          in_bcast;
  logic          in_valid;
  logic          in_ready;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0] out_valid;
  logic [CH-1:0] out_ready;
  logic          err;

  logic          b_reset;
  logic [W-1:0]  b_data;
  logic [2:0]    b_sel;
  logic          b_bcast;
  logic          b_valid;
  logic          b_ready;
  logic [CB*W-1:0] b_odata;
  logic [CB-1:0] b_ovalid;
  logic [CB-1:0] b_ordy;
  logic          b_err;

  int compared = 0;
  int mismatched = 0;

  bit          mfull [CH];
  logic [W-1:0] mdat [CH];
  bit          merr;
  bit          exp_rdy;

  always #5 clk = ~clk;

  dmux_stream #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .err(err)
  );

  dmux_stream #(.WIDTH(W), .CHANNELS(CB)) dut_b (
    .clk(clk), .reset(b_reset),
    .in_data(b_data), .in_sel(b_sel),
    .in_bcast(b_bcast), .in_valid(b_valid),
    .in_ready(b_ready), .out_data(b_odata),
    .out_valid(b_ovalid), .out_ready(b_ordy),
    .err(b_err)
  );

  task automatic chk(string tag, logic [127:0] got,
                     logic [127:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready();
    bit r;
    if (in_bcast) begin
      r = 1;
      for (int k = 0; k < CH; k++)
        if (mfull[k] && !out_ready[k]) r = 0;
    end else begin
      r = !mfull[in_sel] || out_ready[in_sel];
    end
    return r;
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int k = 0; k < CH; k++) begin
        mfull[k] = 0;
        mdat[k]  = '0;
      end
      merr = 0;
      return;
    end
    for (int k = 0; k < CH; k++)
      if (mfull[k] && out_ready[k]) mfull[k] = 0;
    if (in_valid && exp_rdy) begin
      for (int k = 0; k < CH; k++) begin
        if (in_bcast || int'(in_sel) == k) begin
          mfull[k] = 1;
          mdat[k]  = in_data;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [CH*W-1:0] ed;
    logic [CH-1:0]   ev;
    #3;
    exp_rdy = model_ready();
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    model_edge();
    @(posedge clk);
    #1;
    for (int k = 0; k < CH; k++) begin
      ev[k] = mfull[k];
      ed[k*W +: W] = mdat[k];
    end
    chk("out_valid", 128'(out_valid), 128'(ev));
    chk("out_data", 128'(out_data), 128'(ed));
    chk("err", 128'(err), 128'(merr));
  endtask

  task automatic send(logic [W-1:0] d, logic [2:0] s,
                      logic bc);
    in_data = d; in_sel = s; in_bcast = bc; in_valid = 1;
  endtask

  initial begin
    reset = 1; in_data = 0; in_sel = 0; in_bcast = 0;
    in_valid = 0; out_ready = '1;
    b_reset = 1; b_data = 0; b_sel = 0; b_bcast = 0;
    b_valid = 0; b_ordy = '1;
    merr = 0;
    for (int k = 0; k < CH; k++) begin
      mfull[k] = 0; mdat[k] = '0;
    end
    cycle(); cycle();
    reset = 0; b_reset = 0;
    chk("reset_valid", 128'(out_valid), 128'(0));
    chk("reset_data", 128'(out_data), 128'(0));

    // unicast
    send(16'h1234, 3'd5, 0); cycle();
    chk("uni_valid", 128'(out_valid), 128'(8'b0010_0000));
    chk("uni_data", 128'(out_data[5*W +: W]), 128'(16'h1234));
    in_valid = 0; cycle();
    chk("uni_clear", 128'(out_valid), 128'(0));

    // backpressure
    out_ready = 8'hFB;
    send(16'hAAAA, 3'd2, 0); cycle();
    send(16'hBBBB, 3'd2, 0); cycle();
    chk("bp_ready", 128'(in_ready), 128'(0));
    chk("bp_hold", 128'(out_data[2*W +: W]), 128'(16'hAAAA));
    cycle();
    out_ready = 8'hFF; cycle();
    chk("bp_new", 128'(out_data[2*W +: W]), 128'(16'hBBBB));
    in_valid = 0; cycle();

    // isolation
    out_ready = 8'hFB;
    send(16'h0011, 3'd2, 0); cycle();
    send(16'h0007, 3'd3, 0); cycle();
    chk("iso_valid", 128'(out_valid), 128'(8'b0000_1100));
    in_valid = 0; cycle();
    out_ready = 8'hFF; cycle();

    // broadcast
    out_ready = 8'hBF;
    send(16'h0066, 3'd6, 0); cycle();
    send(16'hBEEF, 3'd1, 1); cycle(); cycle();
    chk("bc_stall", 128'(in_ready), 128'(0));
    out_ready = 8'h40; cycle();
    in_valid = 0; out_ready = 8'h00; cycle();
    chk("bc_valid", 128'(out_valid), 128'(8'hFF));
    chk("bc_data", 128'(out_data), 128'({CH{16'hBEEF}}));
    out_ready = 8'hFF; cycle();

    // reset mid-stream
    out_ready = 8'h00;
    send(16'h0F0F, 3'd0, 0); cycle();
    send(16'h4444, 3'd4, 0); cycle();
    send(16'h9999, 3'd1, 0); reset = 1; cycle();
    reset = 0; in_valid = 0;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data", 128'(out_data), 128'(0));
    out_ready = 8'hFF;

    // out-of-range on the 6-channel instance
    b_data = 16'h5555; b_sel = 3'd7; b_valid = 1;
    #2;
    chk("oor_ready", 128'(b_ready), 128'(1));
    cycle();
    chk("oor_valid", 128'(b_ovalid), 128'(0));
    chk("oor_err", 128'(b_err), 128'(1));
    b_valid = 0; cycle(); cycle();
    chk("oor_sticky", 128'(b_err), 128'(1));
    b_data = 16'h0A0A; b_sel = 3'd5; b_valid = 1;
    #2;
    chk("b5_ready", 128'(b_ready), 128'(1));
    cycle();
    chk("b5_valid", 128'(b_ovalid), 128'(6'b10_0000));
    chk("b5_data", 128'(b_odata[5*W +: W]), 128'(16'h0A0A));
    b_sel = 3'd6; b_data = 16'h6666; cycle();
    chk("b6_valid", 128'(b_ovalid), 128'(0));
    chk("b6_data", 128'(b_odata[5*W +: W]), 128'(16'h0A0A));
    b_valid = 0; b_reset = 1; cycle();
    b_reset = 0;
    chk("b_rst_err", 128'(b_err), 128'(0));
    chk("b_rst_data", 128'(b_odata), 128'(0));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      out_ready = CH'($urandom);
      if (!(in_valid && !exp_rdy)) begin
        in_valid = ($urandom % 4) != 0;
        in_sel   = 3'($urandom);
        in_bcast = ($urandom % 8) == 0;
        in_data  = W'($urandom);
      end
      reset = ($urandom % 64) == 0;
      cycle();
    end
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
